// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//   Shares the single cache-bus master port among NUM_PORTS internal
//   requesters (port 0 = ibus, port 1 = dbus). One requester is granted at a
//   time, and the grant is held until that requester's ready && last beat.
//   The winner's request goes to the bus unchanged, and the bus response is
//   routed back only to the winner.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   ireqs   in   cbus_req_t  [NUM_PORTS]  per-requester requests
//   iresps  out  cbus_resp_t [NUM_PORTS]  per-requester responses
//   oreq    out  cbus_req_t               request to the shared bus
//   oresp   in   cbus_resp_t              response from the shared bus
//
// Build option
//   CBUS_ARB_ROUND_ROBIN_EN  defined   : round-robin start index advances
//                                        after each completed transaction
//                            undefined : fixed priority, lowest index wins
// -----------------------------------------------------------------------------

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

// state | meaning
// IDLE  | no grant; outputs zero; pick a winner from the valid requesters
// BUSY  | ireqs[sel] drives oreq, oresp goes to iresps[sel]; leave on ready && last
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_PORTS],
    output cbus_resp_t iresps [NUM_PORTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int SW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] sel;
    logic [SW-1:0] sel_next;
    logic [SW-1:0] prio;
    logic [SW-1:0] winner;
    logic          found;
    logic          done;

    assign done = oresp.ready && oresp.last;

    // Circular scan starting at prio; the first valid index wins.
    always_comb begin
        logic [SW-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = SW'((int'(prio) + k) % NUM_PORTS);
            if (!found && ireqs[idx].valid) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = BUSY;
                    sel_next   = winner;
                end
            end
            BUSY: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The granted request, valid included, passes straight through, so a
    // requester dropping valid mid-transaction is visible on the bus. The
    // grant is still held until ready && last.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            iresps[i] = '0;
        end
        if (state == BUSY) begin
            oreq        = ireqs[sel];
            iresps[sel] = oresp;
        end
    end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    // After a transaction completes, the port after the one just served has
    // first claim on the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= '0;
        end else if (state == BUSY && done) begin
            prio <= (sel == SW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
        end
    end
`else
    assign prio = '0;
`endif

endmodule
